data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, word count of internal storage (1 KiB).
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to completion (range 1..15).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 READ  input  4  bit3 = read enable; bits[2:0] = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-006 WRITE  input  3  bit2 = write enable; bits[1:0] = funct3[1:0] (00 SB, 01 SH, 10 SW).
REQ-007 ADDRESS  input  32  byte address from MA stage.
REQ-008 WRITEDATA  input  32  store data, LSB-aligned.
REQ-009 READDATA  output  32  extended load result, registered.
REQ-010 BUSYWAIT  output  1  stall request to CPU pipeline.
REQ-011 MISALIGNED  output  1  one-cycle pulse on misaligned or illegal-encoding access.

Function
REQ-012 FSM states: IDLE, BUSY, DONE.
REQ-013 Request = READ[3] | WRITE[2], sampled only in IDLE.
REQ-014 IDLE + request: BUSYWAIT high combinationally same cycle; latch ADDRESS, WRITEDATA, op; load counter with LATENCY-1; go BUSY.
REQ-015 BUSY: BUSYWAIT high; counter decrements; at counter 0 perform access, go DONE.
REQ-016 DONE: BUSYWAIT low for exactly one cycle; READDATA valid; inputs ignored; next state IDLE unconditionally.
REQ-017 Total stall = LATENCY+1 cycles with BUSYWAIT high, then one DONE cycle.
REQ-018 Word index = ADDRESS[9:2] modulo DEPTH_WORDS; upper address bits ignored (wrap-around).
REQ-019 SB writes byte lane ADDRESS[1:0]; SH writes half lane ADDRESS[1]; SW writes full word; other lanes unchanged.
REQ-020 LB/LH sign-extend; LBU/LHU zero-extend; LW returns word unchanged.
REQ-021 Misaligned: LH/LHU/SH with ADDRESS[0]=1, LW/SW with ADDRESS[1:0]!=0 -> no memory write, READDATA=0, MISALIGNED pulses in DONE cycle; timing unchanged.
REQ-022 Illegal funct3 (READ[2:0] in {011,110,111}, WRITE[1:0]=11) treated as misaligned.
REQ-023 READ and WRITE enabled together: write performed, READDATA=0, MISALIGNED pulses.
REQ-024 After a write, READDATA holds its previous value.

Reset
REQ-025 RST in any state: next state IDLE, counter 0, READDATA 0, BUSYWAIT 0, MISALIGNED 0.
REQ-026 RST mid-operation aborts the access; a pending write is not committed.
REQ-027 Storage contents not cleared by RST.
REQ-028 BUSYWAIT is combinationally low during the cycle RST is high.

Structure
REQ-029 Package data_mem_ctrl_pkg holds funct3 load/store encodings, FSM state enum, default DEPTH_WORDS/LATENCY.
REQ-030 Sub-module data_mem_lane_align: combinational store byte-enable/merge and load extract/extend; controller holds FSM, counter, storage.
REQ-031 Storage inferred as single-port synchronous RAM suitable for FPGA block RAM.

Verification
REQ-032 SW 0xDEADBEEF @0x10, then LW @0x10 -> BUSYWAIT high 3 cycles each (LATENCY=2), READDATA=0xDEADBEEF in DONE.
REQ-033 After REQ-032, SB 0x7F @0x11, LB @0x11 -> 0x0000007F; LW @0x10 -> 0xDEAD7FEF; LBU @0x13 -> 0x000000DE; LB @0x13 -> 0xFFFFFFDE.
REQ-034 SH 0x8001 @0x22, LH @0x22 -> 0xFFFF8001, LHU @0x22 -> 0x00008001.
REQ-035 LW @0x12 and SH @0x23 -> MISALIGNED pulse in DONE, READDATA=0, word @0x20 unchanged.
REQ-036 RST asserted 1 cycle into SW 0x12345678 @0x40 -> BUSYWAIT 0 next cycle, subsequent LW @0x40 returns prior contents.
REQ-037 Back-to-back LW requests held across DONE -> exactly two accesses, second accepted in IDLE cycle after DONE; LW @0x410 returns word @0x010 (wrap).

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg
// Shared definitions for the data memory controller: load/store funct3
// encodings, the controller FSM state type and default sizing parameters.
package data_mem_ctrl_pkg;

  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_LATENCY     = 2;

  // Load funct3 (READ[2:0])
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3[1:0] (WRITE[1:0])
  localparam logic [1:0] F3_SB = 2'b00;
  localparam logic [1:0] F3_SH = 2'b01;
  localparam logic [1:0] F3_SW = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if
// CPU <-> data memory bus.
//   READ[3] read enable, READ[2:0] load funct3
//   WRITE[2] write enable, WRITE[1:0] store funct3[1:0]
//   ADDRESS byte address, WRITEDATA LSB-aligned store data
//   READDATA extended load result, BUSYWAIT stall, MISALIGNED fault pulse
// master = CPU side, slave = memory controller side.
interface data_mem_ctrl_if;
  logic [3:0]  READ;
  logic [2:0]  WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITEDATA;
  logic [31:0] READDATA;
  logic        BUSYWAIT;
  logic        MISALIGNED;

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA,
    input  READDATA, BUSYWAIT, MISALIGNED
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA,
    output READDATA, BUSYWAIT, MISALIGNED
  );
endinterface

// File: rtl/data_mem_lane_align.sv
// data_mem_lane_align
// Combinational lane logic for the data memory.
//   Inputs : rd_en/ld_f3, wr_en/st_f3 (latched op), byte_off (ADDRESS[1:0]),
//            st_data (LSB-aligned store data), ld_word (word read from RAM)
//   Outputs: st_be/st_word (byte enables + replicated store data, zero
//            enables when the store must not commit), ld_result (extended
//            load value, 0 on any fault or read+write), fault (misaligned,
//            illegal encoding, or read and write together)
module data_mem_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic        rd_en,
  input  logic [2:0]  ld_f3,
  input  logic        wr_en,
  input  logic [1:0]  st_f3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_be,
  output logic [31:0] st_word,
  output logic [31:0] ld_result,
  output logic        fault
);

  logic        ld_ok, st_ok;
  logic [31:0] ld_val;
  logic [3:0]  be_raw;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = ld_word[{byte_off, 3'b000} +: 8];
  assign lane_h = ld_word[{byte_off[1], 4'b0000} +: 16];

  always_comb begin
    ld_ok  = 1'b0;
    ld_val = 32'd0;
    case (ld_f3)
      F3_LB:  begin ld_ok = 1'b1;              ld_val = {{24{lane_b[7]}}, lane_b};  end
      F3_LBU: begin ld_ok = 1'b1;              ld_val = {24'd0, lane_b};            end
      F3_LH:  begin ld_ok = !byte_off[0];      ld_val = {{16{lane_h[15]}}, lane_h}; end
      F3_LHU: begin ld_ok = !byte_off[0];      ld_val = {16'd0, lane_h};            end
      F3_LW:  begin ld_ok = (byte_off == 2'd0); ld_val = ld_word;                   end
      default: ld_ok = 1'b0;
    endcase
  end

  always_comb begin
    st_ok   = 1'b0;
    be_raw  = 4'd0;
    st_word = st_data;
    case (st_f3)
      F3_SB: begin st_ok = 1'b1;              be_raw = 4'b0001 << byte_off;               st_word = {4{st_data[7:0]}};  end
      F3_SH: begin st_ok = !byte_off[0];      be_raw = 4'b0011 << {byte_off[1], 1'b0};    st_word = {2{st_data[15:0]}}; end
      F3_SW: begin st_ok = (byte_off == 2'd0); be_raw = 4'b1111;                          st_word = st_data;            end
      default: st_ok = 1'b0;
    endcase
  end

  // A store commits whenever it is itself legal, even when paired with a read.
  assign st_be     = (wr_en && st_ok) ? be_raw : 4'd0;
  assign fault     = (rd_en && wr_en) || (rd_en && !ld_ok) || (wr_en && !st_ok);
  assign ld_result = (rd_en && !wr_en && ld_ok) ? ld_val : 32'd0;

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Multi-cycle data memory with a fixed access latency.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : data_mem_ctrl_if.slave (READ, WRITE, ADDRESS, WRITEDATA in;
//              READDATA, BUSYWAIT, MISALIGNED out)
// A request seen in IDLE stalls the CPU for LATENCY+1 cycles, then one DONE
// cycle presents the result. Storage is a single-port synchronous RAM with
// byte enables; contents survive reset.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic          CLK,
  input  logic          RST,
  data_mem_ctrl_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  function automatic logic [IDX_W-1:0] word_idx(input logic [7:0] w);
    return IDX_W'({24'd0, w} % 32'(DEPTH_WORDS));
  endfunction

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] rdata_q;
  logic        mis_q;

  logic        op_rd, op_wr;
  logic [2:0]  op_lf;
  logic [1:0]  op_sf;
  logic [9:0]  addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] ram_q;
  logic [IDX_W-1:0] ram_idx;

  logic        req, access, mem_we, fault;
  logic [3:0]  st_be;
  logic [31:0] st_word, ld_result;
  logic        addr_hi_unused;

  assign addr_hi_unused = ^bus.ADDRESS[31:10];

  assign req    = bus.READ[3] | bus.WRITE[2];
  assign access = (state == S_BUSY) && (cnt == 4'd0);
  assign mem_we = access && !RST;

  assign bus.BUSYWAIT   = !RST && (((state == S_IDLE) && req) || (state == S_BUSY));
  assign bus.READDATA   = rdata_q;
  assign bus.MISALIGNED = mis_q;

  // In IDLE the RAM is addressed straight from the bus so the word is
  // already in ram_q by the first BUSY cycle (needed when LATENCY = 1).
  assign ram_idx = (state == S_IDLE) ? word_idx(bus.ADDRESS[9:2]) : word_idx(addr_q[9:2]);

  data_mem_lane_align u_align (
    .rd_en     (op_rd),
    .ld_f3     (op_lf),
    .wr_en     (op_wr),
    .st_f3     (op_sf),
    .byte_off  (addr_q[1:0]),
    .st_data   (wdata_q),
    .ld_word   (ram_q),
    .st_be     (st_be),
    .st_word   (st_word),
    .ld_result (ld_result),
    .fault     (fault)
  );

  // Single-port RAM, read-first; the write lands on the final BUSY edge.
  always_ff @(posedge CLK) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && st_be[b]) mem[ram_idx][8*b +: 8] <= st_word[8*b +: 8];
    end
    ram_q <= mem[ram_idx];
  end

  // Request capture (data path, not reset)
  always_ff @(posedge CLK) begin
    if ((state == S_IDLE) && req) begin
      op_rd   <= bus.READ[3];
      op_lf   <= bus.READ[2:0];
      op_wr   <= bus.WRITE[2];
      op_sf   <= bus.WRITE[1:0];
      addr_q  <= bus.ADDRESS[9:0];
      wdata_q <= bus.WRITEDATA;
    end
  end

  // Control FSM with registered READDATA / MISALIGNED
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            cnt   <= 4'(LATENCY - 1);
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt == 4'd0) begin
            state <= S_DONE;
            mis_q <= fault;
            // A clean write-only access leaves READDATA untouched.
            if (op_rd || fault) rdata_q <= ld_result;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
